// File: rtl/decode_pkg.sv
// decode_pkg: opcode, ALU-control and result-source codes plus the ID/EX control bundle
package decode_pkg;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef struct packed {
        logic       regwrite;
        logic [1:0] resultsrc;
        logic       memwrite;
        logic       branch;
        logic       jump;
        logic       alusrc;
        logic [2:0] alucontrol;
        logic       valid;
        logic       illegal;
    } ctrl_t;
endpackage

// File: rtl/decode_stage_regfile.sv
// decode_stage_regfile: NREGS x XLEN register file, x0 hardwired to zero, two async reads
// Ports: clk, rst (async, active-high, clears all entries); ra1/ra2 -> rd1/rd2 reads;
//        we/wa/wd write port (ignored when wa == 0).
// Macro DECODE_WB_BYPASS_EN: a same-cycle write to the register being read is forwarded.
module decode_stage_regfile #(
    parameter  int XLEN    = 32,
    parameter  int NREGS   = 32,
    localparam int RADDR_W = $clog2(NREGS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [RADDR_W-1:0] ra1,
    input  logic [RADDR_W-1:0] ra2,
    output logic [XLEN-1:0]    rd1,
    output logic [XLEN-1:0]    rd2,
    input  logic               we,
    input  logic [RADDR_W-1:0] wa,
    input  logic [XLEN-1:0]    wd
);
`ifdef DECODE_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif
    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic            wr_en;

    assign wr_en = we && (wa != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) regs_d[wa] = wd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) regs_q <= '{default: '0};
        else     regs_q <= regs_d;
    end

    assign rd1 = (ra1 == '0) ? '0 : (BYPASS && wr_en && wa == ra1) ? wd : regs_q[ra1];
    assign rd2 = (ra2 == '0) ? '0 : (BYPASS && wr_en && wa == ra2) ? wd : regs_q[ra2];
endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode with register file, control/immediate decode and ID/EX bank
// Ports: clk, rst (async, active-high); InstrD/PCD/PCPlus4D/ValidD from IF/ID;
//        StallD holds and FlushE bubbles the ID/EX bank; RegWriteW/RDW/ResultW writeback;
//        *_E registered controls, operands and register indices.
// Macro DECODE_WB_BYPASS_EN: enables writeback-to-read forwarding inside the register file.
module decode_stage
    import decode_pkg::*;
#(
    parameter  int XLEN    = 32,
    parameter  int NREGS   = 32,
    localparam int RADDR_W = $clog2(NREGS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        InstrD,
    input  logic [XLEN-1:0]    PCD,
    input  logic [XLEN-1:0]    PCPlus4D,
    input  logic               ValidD,
    input  logic               StallD,
    input  logic               FlushE,
    input  logic               RegWriteW,
    input  logic [RADDR_W-1:0] RDW,
    input  logic [XLEN-1:0]    ResultW,
    output logic               RegWriteE,
    output logic               MemWriteE,
    output logic               BranchE,
    output logic               JumpE,
    output logic               ALUSrcE,
    output logic               ValidE,
    output logic               IllegalE,
    output logic [1:0]         ResultSrcE,
    output logic [2:0]         ALUControlE,
    output logic [XLEN-1:0]    RD1_E,
    output logic [XLEN-1:0]    RD2_E,
    output logic [XLEN-1:0]    Imm_Ext_E,
    output logic [XLEN-1:0]    PCE,
    output logic [XLEN-1:0]    PCPlus4E,
    output logic [RADDR_W-1:0] RS1_E,
    output logic [RADDR_W-1:0] RS2_E,
    output logic [RADDR_W-1:0] RD_E
);
    localparam int IDEX_W = $bits(ctrl_t) + 5 * XLEN + 3 * RADDR_W;

    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [RADDR_W-1:0] rs1, rs2, rd;
    logic [XLEN-1:0]    rf_rd1, rf_rd2, imm;
    logic [XLEN-1:0]    imm_i, imm_s, imm_b, imm_j;
    logic [2:0]         alu_op;
    ctrl_t              dec, ctrl_e;
    logic [IDEX_W-1:0]  idex_d, idex_q;

    assign opcode = InstrD[6:0];
    assign funct3 = InstrD[14:12];
    assign rs1    = InstrD[15 +: RADDR_W];
    assign rs2    = InstrD[20 +: RADDR_W];
    assign rd     = InstrD[7 +: RADDR_W];

    assign imm_i = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
    assign imm_s = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
    assign imm_b = {{(XLEN-13){InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
    assign imm_j = {{(XLEN-21){InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};

    // funct7[5] selects sub only for register-register add
    assign alu_op = funct3 == 3'b010 ? ALU_SLT :
                    funct3 == 3'b110 ? ALU_OR  :
                    funct3 == 3'b111 ? ALU_AND :
                    (funct3 == 3'b000 && opcode == OP_RTYPE && InstrD[30]) ? ALU_SUB : ALU_ADD;

    decode_stage_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
        .clk (clk),
        .rst (rst),
        .ra1 (rs1),
        .ra2 (rs2),
        .rd1 (rf_rd1),
        .rd2 (rf_rd2),
        .we  (RegWriteW),
        .wa  (RDW),
        .wd  (ResultW)
    );

    always_comb begin
        dec           = '0;
        dec.resultsrc = RES_ALU;
        dec.alucontrol = ALU_ADD;
        dec.valid     = 1'b1;
        imm           = '0;
        case (opcode)
            OP_LOAD: begin
                dec.regwrite  = 1'b1;
                dec.resultsrc = RES_MEM;
                dec.alusrc    = 1'b1;
                imm           = imm_i;
            end
            OP_STORE: begin
                dec.memwrite = 1'b1;
                dec.alusrc   = 1'b1;
                imm          = imm_s;
            end
            OP_RTYPE: begin
                dec.regwrite   = 1'b1;
                dec.alucontrol = alu_op;
            end
            OP_ITYPE: begin
                dec.regwrite   = 1'b1;
                dec.alusrc     = 1'b1;
                dec.alucontrol = alu_op;
                imm            = imm_i;
            end
            OP_BRANCH: begin
                dec.branch     = 1'b1;
                dec.alucontrol = ALU_SUB;
                imm            = imm_b;
            end
            OP_JAL: begin
                dec.regwrite  = 1'b1;
                dec.jump      = 1'b1;
                dec.resultsrc = RES_PC4;
                imm           = imm_j;
            end
            default: dec.illegal = 1'b1;
        endcase
        // a non-valid slot becomes a bubble; data fields are still captured
        if (!ValidD) dec = '0;
    end

    always_comb begin
        idex_d = FlushE ? '0 : StallD ? idex_q :
                 {dec, rf_rd1, rf_rd2, imm, PCD, PCPlus4D, rs1, rs2, rd};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) idex_q <= '0;
        else     idex_q <= idex_d;
    end

    assign {ctrl_e, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RS1_E, RS2_E, RD_E} = idex_q;
    assign RegWriteE   = ctrl_e.regwrite;
    assign ResultSrcE  = ctrl_e.resultsrc;
    assign MemWriteE   = ctrl_e.memwrite;
    assign BranchE     = ctrl_e.branch;
    assign JumpE       = ctrl_e.jump;
    assign ALUSrcE     = ctrl_e.alusrc;
    assign ALUControlE = ctrl_e.alucontrol;
    assign ValidE      = ctrl_e.valid;
    assign IllegalE    = ctrl_e.illegal;
endmodule
